// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the RX FIFO and the TX path.
package uart_pkg;
   localparam int UART_DBITS = 8;
   typedef logic [UART_DBITS-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host bundle for the UART RX FIFO: write strobe, read request,
// read data and status flags.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int DBITS = UART_DBITS,
   parameter int DEPTH = 16
) ();
   localparam int AW = $clog2(DEPTH);

   logic             rx_done;
   logic [DBITS-1:0] rx_dout;
   logic             rd_en;
   logic             clr_overrun;
   logic [DBITS-1:0] rd_data;
   logic             rd_valid;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic [AW:0]      count;
   logic             overrun;

   modport master (
      output rx_done, rx_dout, rd_en, clr_overrun,
      input  rd_data, rd_valid, empty, full,
      input  almost_full, count, overrun
   );

   modport slave (
      input  rx_done, rx_dout, rd_en, clr_overrun,
      output rd_data, rd_valid, empty, full,
      output almost_full, count, overrun
   );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DBITS = UART_DBITS,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [DBITS-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [DBITS-1:0] rdata
);
   logic [DBITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer behind the UART receiver with overrun tracking.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DBITS    = UART_DBITS,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input logic          clk,
   input logic          reset,
   uart_rx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      cnt;
   logic             empty;
   logic             full;
   logic             rd_ok;
   logic             wr_ok;
   logic             drop;
   logic [DBITS-1:0] mem_q;

   // Wrap bit distinguishes full from empty when the low bits match.
   assign cnt   = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   assign rd_ok = bus.rd_en && !empty;
   assign wr_ok = bus.rx_done && (!full || rd_ok);
   assign drop  = bus.rx_done && full && !rd_ok;

   uart_fifo_mem #(
      .DBITS (DBITS),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.rx_dout),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (mem_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // A fresh drop beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.overrun <= 1'b0;
      end else if (drop) begin
         bus.overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
         bus.overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_FWFT_EN
   assign bus.rd_data  = mem_q;
   assign bus.rd_valid = !empty;
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= rd_ok;
         if (rd_ok) bus.rd_data <= mem_q;
      end
   end
`endif

   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.count       = cnt;
   assign bus.almost_full = (cnt >= (AW+1)'(AF_LEVEL));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; expectations follow the active read mode.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;

   uart_rx_fifo_if #(.DBITS(8), .DEPTH(16)) bus ();

   uart_rx_fifo #(
      .DBITS    (8),
      .DEPTH    (16),
      .AF_LEVEL (12)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input uart_byte_t b);
      bus.rx_done = 1'b1;
      bus.rx_dout = b;
      cyc();
      bus.rx_done = 1'b0;
   endtask

   // Pops one word and checks it; back-to-back calls read on consecutive cycles.
   task automatic pop_chk(input string tag, input uart_byte_t exp);
`ifdef UART_RX_FIFO_FWFT_EN
      chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
      chk(tag, 32'(bus.rd_data), 32'(exp));
      bus.rd_en = 1'b1;
      cyc();
      bus.rd_en = 1'b0;
`else
      bus.rd_en = 1'b1;
      cyc();
      bus.rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
      chk(tag, 32'(bus.rd_data), 32'(exp));
`endif
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   uart_byte_t q[$];
   uart_byte_t b;

   initial begin
      n_vec = 0;
      n_bad = 0;
      bus.rx_done     = 1'b0;
      bus.rx_dout     = '0;
      bus.rd_en       = 1'b0;
      bus.clr_overrun = 1'b0;
      do_reset();

      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_af", 32'(bus.almost_full), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_vld", 32'(bus.rd_valid), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
      chk("rst_data", 32'(bus.rd_data), 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         bus.rd_en = 1'b1;
         cyc();
         bus.rd_en = 1'b0;
         chk("idle_rd_vld", 32'(bus.rd_valid), 32'd0);
         chk("idle_rd_cnt", 32'(bus.count), 32'd0);
      end

      push(8'hA5);
`ifdef UART_RX_FIFO_FWFT_EN
      chk("fall_vld", 32'(bus.rd_valid), 32'd1);
      chk("fall_data", 32'(bus.rd_data), 32'hA5);
`else
      chk("wr_no_vld", 32'(bus.rd_valid), 32'd0);
`endif
      push(8'h3C);
      push(8'hFF);
      chk("three_cnt", 32'(bus.count), 32'd3);
      pop_chk("rd0", 8'hA5);
      pop_chk("rd1", 8'h3C);
      pop_chk("rd2", 8'hFF);
      chk("three_drain", 32'(bus.count), 32'd0);
      chk("three_empty", 32'(bus.empty), 32'd1);

      // Fill, overflow and drain.
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("fill_cnt", 32'(bus.count), 32'(i + 1));
         chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 12));
         chk("fill_full", 32'(bus.full), 32'((i + 1) == 16));
      end
      chk("fill_ovr0", 32'(bus.overrun), 32'd0);
      push(8'h55);
      chk("drop_cnt", 32'(bus.count), 32'd16);
      chk("drop_ovr", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < 16; i++) pop_chk("drain", 8'(i));
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("drain_ovr", 32'(bus.overrun), 32'd1);
      bus.clr_overrun = 1'b1;
      cyc();
      bus.clr_overrun = 1'b0;
      chk("clr_ovr", 32'(bus.overrun), 32'd0);

      // Simultaneous read and write while empty: only the write lands.
      bus.rx_done = 1'b1;
      bus.rx_dout = 8'h9E;
      bus.rd_en   = 1'b1;
      cyc();
      bus.rx_done = 1'b0;
      bus.rd_en   = 1'b0;
`ifdef UART_RX_FIFO_FWFT_EN
      chk("erw_vld", 32'(bus.rd_valid), 32'd1);
`else
      chk("erw_vld", 32'(bus.rd_valid), 32'd0);
`endif
      chk("erw_cnt", 32'(bus.count), 32'd1);
      pop_chk("erw_rd", 8'h9E);

      // Simultaneous read and write while full.
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      chk("frw_full", 32'(bus.full), 32'd1);
`ifdef UART_RX_FIFO_FWFT_EN
      chk("frw_data", 32'(bus.rd_data), 32'h10);
`endif
      bus.rx_done = 1'b1;
      bus.rx_dout = 8'h77;
      bus.rd_en   = 1'b1;
      cyc();
      bus.rx_done = 1'b0;
      bus.rd_en   = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
      chk("frw_data", 32'(bus.rd_data), 32'h10);
`endif
      chk("frw_cnt", 32'(bus.count), 32'd16);
      chk("frw_ovr", 32'(bus.overrun), 32'd0);
      for (int i = 1; i < 16; i++) pop_chk("frw_drain", 8'(8'h10 + i));
      pop_chk("frw_last", 8'h77);
      chk("frw_empty", 32'(bus.empty), 32'd1);

      // Forty bytes across pointer wrap with a shallow occupancy.
      for (int i = 0; i < 40; i++) begin
         b = 8'(i * 37 + 11);
         push(b);
         q.push_back(b);
         if (q.size() >= 4) pop_chk("wrap", q.pop_front());
         chk("wrap_cnt", 32'(bus.count), 32'(q.size()));
      end
      while (q.size() > 0) pop_chk("wrap_tail", q.pop_front());
      chk("wrap_empty", 32'(bus.empty), 32'd1);

      // Clear colliding with a new drop: the drop wins.
      for (int i = 0; i < 16; i++) push(8'(i));
      push(8'hEE);
      chk("col_ovr_set", 32'(bus.overrun), 32'd1);
      bus.rx_done     = 1'b1;
      bus.rx_dout     = 8'hEF;
      bus.clr_overrun = 1'b1;
      cyc();
      bus.rx_done     = 1'b0;
      bus.clr_overrun = 1'b0;
      chk("col_ovr_keep", 32'(bus.overrun), 32'd1);
      chk("col_cnt", 32'(bus.count), 32'd16);

      // Asynchronous reset mid-stream.
      do_reset();
      for (int i = 0; i < 7; i++) push(8'(8'h40 + i));
      chk("mid_cnt", 32'(bus.count), 32'd7);
      reset = 1'b0;
      #1;
      chk("mid_empty", 32'(bus.empty), 32'd1);
      chk("mid_count", 32'(bus.count), 32'd0);
      chk("mid_ovr", 32'(bus.overrun), 32'd0);
      cyc();
      reset = 1'b1;
      cyc();
      chk("post_vld", 32'(bus.rd_valid), 32'd0);
      push(8'h5A);
      pop_chk("post_rd", 8'h5A);
      chk("post_empty", 32'(bus.empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
